// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-fetch bus between the PC controller (master) and the hazard unit,
// branch logic and instruction memory (slave).
interface fetch_pc_ctrl_if #(
  parameter int MEM_SPACE = 8
);
  logic                 stall;
  logic                 redirect;
  logic [MEM_SPACE-1:0] redirect_pc;
  logic                 halt;
  logic [MEM_SPACE-1:0] address;
  logic                 PChold;
  logic                 PCctrl;
  logic [MEM_SPACE-1:0] fetch_pc;
  logic                 fetch_valid;

  modport master (
    input  stall, redirect, redirect_pc, halt,
    output address, PChold, PCctrl, fetch_pc, fetch_valid
  );

  modport slave (
    output stall, redirect, redirect_pc, halt,
    input  address, PChold, PCctrl, fetch_pc, fetch_valid
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Program-counter owner for instruction fetch: stalls, redirects with a
// programmable NOP bubble count, halt, and tracking of the word on memory data_out.
module fetch_pc_ctrl #(
  parameter int                   MEM_SPACE    = 8,
  parameter logic [MEM_SPACE-1:0] RESET_PC     = '0,
  parameter int                   FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  fetch_pc_ctrl_if.master    bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT =
    CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e               state_q;
  logic [MEM_SPACE-1:0] pc_q;
  logic [CNT_W-1:0]     flush_cnt_q;
  logic                 prev_real_q;
  logic [MEM_SPACE-1:0] fetch_pc_q;
  logic                 fetch_valid_q;

  logic                 pchold_d;
  logic                 pcctrl_d;
  logic [MEM_SPACE-1:0] pc_inc_d;

  assign pc_inc_d = pc_q + MEM_SPACE'(1);

  // Memory controls follow the same priority as the state update below.
  always_comb begin
    pchold_d = 1'b0;
    pcctrl_d = 1'b1;
    if (rst) begin
      pcctrl_d = 1'b1;
    end else if (state_q == HALTED || bus.halt) begin
      pcctrl_d = 1'b1;
    end else if (bus.redirect) begin
      pcctrl_d = 1'b1;
    end else if (state_q == FLUSH) begin
      pcctrl_d = 1'b1;
    end else if (bus.stall) begin
      // With no real word on data_out there is nothing to repeat, so emit a NOP.
      if (prev_real_q) begin
        pchold_d = 1'b1;
        pcctrl_d = 1'b0;
      end
    end else begin
      pcctrl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      flush_cnt_q   <= '0;
      prev_real_q   <= 1'b0;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
    end else if (state_q == HALTED || bus.halt) begin
      state_q       <= HALTED;
      prev_real_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else if (bus.redirect) begin
      pc_q          <= bus.redirect_pc;
      prev_real_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      flush_cnt_q   <= FLUSH_INIT;
      state_q       <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      prev_real_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      if (flush_cnt_q == '0) begin
        state_q <= RUN;
      end else begin
        flush_cnt_q <= flush_cnt_q - CNT_W'(1);
      end
    end else if (bus.stall) begin
      if (!prev_real_q) begin
        fetch_valid_q <= 1'b0;
      end
    end else begin
      pc_q          <= pc_inc_d;
      fetch_pc_q    <= pc_q;
      fetch_valid_q <= 1'b1;
      prev_real_q   <= 1'b1;
    end
  end

  assign bus.address     = pc_q;
  assign bus.PChold      = pchold_d;
  assign bus.PCctrl      = pcctrl_d;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a cycle-level behavioural model of the
// fetch controller and the instruction memory's one-cycle read view.
module tb_fetch_pc_ctrl;

  localparam int MS = 8;
  localparam int FC = 2;
  localparam int RP = 0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_pc_ctrl_if #(.MEM_SPACE(MS)) bus ();

  fetch_pc_ctrl #(
    .MEM_SPACE   (MS),
    .RESET_PC    (8'(RP)),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: program counter, remaining forced NOP cycles after a redirect,
  // halted flag, whether data_out holds a real word, and the memory's view.
  int m_pc;
  int m_bub;
  bit m_halt;
  bit m_prev;
  int m_fpc;
  bit m_fv;
  bit started;

  function automatic void exp_ctl(output bit h, output bit c);
    h = 1'b0;
    c = 1'b1;
    if (rst) c = 1'b1;
    else if (m_halt || bus.halt) c = 1'b1;
    else if (bus.redirect) c = 1'b1;
    else if (m_bub > 0) c = 1'b1;
    else if (bus.stall) begin
      if (m_prev) begin h = 1'b1; c = 1'b0; end
    end else c = 1'b0;
  endfunction

  always @(posedge clk) begin
    bit eh, ec;
    exp_ctl(eh, ec);
    if (rst) begin
      m_pc = RP; m_bub = 0; m_halt = 0; m_prev = 0; m_fpc = 0; m_fv = 0;
      started = 1'b1;
    end else if (started) begin
      // Memory returns the word at the address it fetched this cycle, or a NOP.
      if (!ec) begin
        m_fv  = 1'b1;
        m_fpc = eh ? (m_pc + 255) % 256 : m_pc;
      end else begin
        m_fv = 1'b0;
      end
      if (m_halt || bus.halt) begin
        m_halt = 1'b1; m_prev = 1'b0;
      end else if (bus.redirect) begin
        m_pc = int'(bus.redirect_pc); m_bub = FC - 1; m_prev = 1'b0;
      end else if (m_bub > 0) begin
        m_bub--; m_prev = 1'b0;
      end else if (!bus.stall) begin
        m_pc = (m_pc + 1) % 256; m_prev = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit eh, ec;
    if (started) begin
      exp_ctl(eh, ec);
      chk("model.address",     int'(bus.address),     m_pc);
      chk("model.PChold",      int'(bus.PChold),      int'(eh));
      chk("model.PCctrl",      int'(bus.PCctrl),      int'(ec));
      chk("model.fetch_valid", int'(bus.fetch_valid), int'(m_fv));
      chk("model.fetch_pc",    int'(bus.fetch_pc),    m_fpc);
    end
  end

  task automatic set(input bit r, input bit s, input bit rd,
                     input logic [7:0] rp, input bit h);
    @(posedge clk);
    #1;
    rst = r; bus.stall = s; bus.redirect = rd; bus.redirect_pc = rp; bus.halt = h;
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) set(0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; started = 1'b0;
    rst = 1'b1; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0; bus.halt = 0;

    // 1: reset and free run
    set(1, 0, 0, 8'h00, 0);
    chk("rst.address", int'(bus.address), 0);
    chk("rst.PCctrl", int'(bus.PCctrl), 1);
    chk("rst.PChold", int'(bus.PChold), 0);
    chk("rst.fetch_valid", int'(bus.fetch_valid), 0);
    set(0, 0, 0, 8'h00, 0);
    chk("run0.address", int'(bus.address), 0);
    chk("run0.PCctrl", int'(bus.PCctrl), 0);
    chk("run0.fetch_valid", int'(bus.fetch_valid), 0);
    set(0, 0, 0, 8'h00, 0);
    chk("run1.address", int'(bus.address), 1);
    chk("run1.fetch_pc", int'(bus.fetch_pc), 0);
    chk("run1.fetch_valid", int'(bus.fetch_valid), 1);
    set(0, 0, 0, 8'h00, 0);
    chk("run2.address", int'(bus.address), 2);
    chk("run2.fetch_pc", int'(bus.fetch_pc), 1);
    set(0, 0, 0, 8'h00, 0);
    chk("run3.address", int'(bus.address), 3);
    chk("run3.fetch_pc", int'(bus.fetch_pc), 2);
    set(0, 0, 0, 8'h00, 0);

    // 2: two-cycle stall at pc=5
    set(0, 1, 0, 8'h00, 0);
    chk("stall1.address", int'(bus.address), 5);
    chk("stall1.PChold", int'(bus.PChold), 1);
    chk("stall1.fetch_pc", int'(bus.fetch_pc), 4);
    set(0, 1, 0, 8'h00, 0);
    chk("stall2.address", int'(bus.address), 5);
    chk("stall2.PChold", int'(bus.PChold), 1);
    chk("stall2.fetch_pc", int'(bus.fetch_pc), 4);
    chk("stall2.fetch_valid", int'(bus.fetch_valid), 1);
    run(2);

    // 3: redirect to 0x20 at pc=7
    set(0, 0, 1, 8'h20, 0);
    chk("redir.address", int'(bus.address), 7);
    chk("redir.PCctrl", int'(bus.PCctrl), 1);
    set(0, 0, 0, 8'h00, 0);
    chk("flush1.address", int'(bus.address), 8'h20);
    chk("flush1.PCctrl", int'(bus.PCctrl), 1);
    chk("flush1.fetch_valid", int'(bus.fetch_valid), 0);
    set(0, 0, 0, 8'h00, 0);
    chk("flush2.PCctrl", int'(bus.PCctrl), 0);
    chk("flush2.fetch_valid", int'(bus.fetch_valid), 0);
    set(0, 0, 0, 8'h00, 0);
    chk("post.address", int'(bus.address), 8'h21);
    chk("post.fetch_pc", int'(bus.fetch_pc), 8'h20);
    chk("post.fetch_valid", int'(bus.fetch_valid), 1);

    // 4: stall and redirect together
    set(0, 1, 1, 8'h40, 0);
    chk("both.PChold", int'(bus.PChold), 0);
    chk("both.PCctrl", int'(bus.PCctrl), 1);
    set(0, 0, 0, 8'h00, 0);
    chk("both.target", int'(bus.address), 8'h40);
    run(2);
    chk("both.fetch_pc", int'(bus.fetch_pc), 8'h40);

    // 5: stall right after reset
    set(1, 0, 0, 8'h00, 0);
    set(0, 1, 0, 8'h00, 0);
    chk("rststall.PChold", int'(bus.PChold), 0);
    chk("rststall.PCctrl", int'(bus.PCctrl), 1);
    set(0, 1, 0, 8'h00, 0);
    chk("rststall.address", int'(bus.address), 0);
    chk("rststall.fetch_valid", int'(bus.fetch_valid), 0);
    run(2);
    chk("rststall.fetch_pc", int'(bus.fetch_pc), 0);

    // 6: wrap, halt, recovery
    set(0, 0, 1, 8'hFF, 0);
    run(3);
    chk("wrap.address", int'(bus.address), 0);
    chk("wrap.fetch_pc", int'(bus.fetch_pc), 8'hFF);
    set(0, 0, 0, 8'h00, 1);
    chk("halt.PCctrl", int'(bus.PCctrl), 1);
    set(0, 0, 1, 8'h55, 0);
    chk("halted.address", int'(bus.address), 1);
    chk("halted.PCctrl", int'(bus.PCctrl), 1);
    chk("halted.fetch_valid", int'(bus.fetch_valid), 0);
    set(0, 1, 0, 8'h00, 0);
    set(0, 0, 0, 8'h00, 0);
    chk("halted2.address", int'(bus.address), 1);
    chk("halted2.PCctrl", int'(bus.PCctrl), 1);
    set(1, 0, 0, 8'h00, 0);
    set(0, 0, 0, 8'h00, 0);
    chk("recover.address", int'(bus.address), 0);
    chk("recover.PCctrl", int'(bus.PCctrl), 0);
    set(0, 0, 0, 8'h00, 0);
    chk("recover.fetch_pc", int'(bus.fetch_pc), 0);
    chk("recover.fetch_valid", int'(bus.fetch_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
